// File: rtl/arb_pkg.sv
// Shared types and constants for the unified memory port arbiter.
// Used by mem_port_arbiter and its priority selector.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_D  = 1'b1;

  localparam int MEM_LAT_MAX = 4;
  localparam int STARVE_W    = 4;
  localparam int LAT_W       = $clog2(MEM_LAT_MAX + 1);

endpackage

// File: rtl/arb_prio_sel.sv
// Priority select: data wins unless fetch has lost STARVE_MAX arbitrations in a row; decision is combinational.
// No backpressure of its own: the starvation count only moves on cycles where arb_en qualifies a request.
module arb_prio_sel
  import arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic if_req,
  input  logic d_req,
  input  logic arb_en,
  output logic win_id,
  output logic win_valid
);

  logic [STARVE_W-1:0] starve_cnt;
  logic                if_starved;

  assign if_starved = (starve_cnt >= STARVE_W'(STARVE_MAX));

  always_comb begin
    win_valid = arb_en & (if_req | d_req);
    win_id    = (d_req & ~(if_req & if_starved)) ? REQ_D : REQ_IF;
  end

  // Saturates so a long data burst cannot wrap the guard back to zero.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      starve_cnt <= '0;
    end else if (win_valid) begin
      if (if_req && (win_id == REQ_D)) begin
        if (!if_starved) starve_cnt <= starve_cnt + 1'b1;
      end else begin
        starve_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store; gnt 1 cycle after request, rvalid at MEM_LAT+2, all outputs registered.
// Not pipelined: requests are ignored while busy and must be held until gnt. Optional ARB_PERF_CNT_EN adds grant/conflict counters.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic [31:0]       perf_if_cnt,
  output logic [31:0]       perf_d_cnt,
  output logic [31:0]       perf_conflict_cnt
);

  state_t           state;
  logic [LAT_W-1:0] lat_cnt;
  logic             owner;
  logic             arb_en;
  logic             win_id;
  logic             win_valid;

  assign arb_en = (state == IDLE);

  arb_prio_sel #(
    .STARVE_MAX(STARVE_MAX)
  ) u_prio_sel (
    .clk      (clk),
    .rstn     (rstn),
    .if_req   (if_req),
    .d_req    (d_req),
    .arb_en   (arb_en),
    .win_id   (win_id),
    .win_valid(win_valid)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      lat_cnt   <= '0;
      owner     <= REQ_IF;
      if_gnt    <= 1'b0;
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
      d_gnt     <= 1'b0;
      d_rvalid  <= 1'b0;
      d_rdata   <= '0;
      mem_cs    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
    end else begin
      if_gnt    <= 1'b0;
      d_gnt     <= 1'b0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      mem_cs    <= 1'b0;
      case (state)
        IDLE: begin
          if (win_valid) begin
            state  <= ISSUE;
            busy   <= 1'b1;
            mem_cs <= 1'b1;
            owner  <= win_id;
            if (win_id == REQ_D) begin
              d_gnt     <= 1'b1;
              mem_we    <= d_we;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
            end else begin
              if_gnt    <= 1'b1;
              mem_we    <= 1'b0;
              mem_addr  <= if_addr;
              mem_wdata <= '0;
            end
          end
        end
        ISSUE: begin
          state   <= WAIT;
          lat_cnt <= LAT_W'(MEM_LAT);
        end
        WAIT: begin
          // Stores sit out the full latency too, so every access takes MEM_LAT+2 cycles.
          if (lat_cnt == LAT_W'(1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            if (owner == REQ_D) begin
              d_rvalid <= 1'b1;
              d_rdata  <= mem_we ? '0 : mem_rdata;
            end else begin
              if_rvalid <= 1'b1;
              if_rdata  <= mem_rdata;
            end
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef ARB_PERF_CNT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_if_cnt       <= '0;
      perf_d_cnt        <= '0;
      perf_conflict_cnt <= '0;
    end else if (win_valid) begin
      if (win_id == REQ_D) perf_d_cnt  <= perf_d_cnt + 32'd1;
      else                 perf_if_cnt <= perf_if_cnt + 32'd1;
      if (if_req && d_req) perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
    end
  end
`else
  assign perf_if_cnt       = '0;
  assign perf_d_cnt        = '0;
  assign perf_conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (MEM_LAT=2, STARVE_MAX=4): per-cycle vector table plus
// hand sequences for starvation, throughput and asynchronous reset during WAIT.
module tb_mem_port_arbiter;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic        clk;
  logic        rstn;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_cs;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        busy;
  logic [31:0] perf_if_cnt;
  logic [31:0] perf_d_cnt;
  logic [31:0] perf_conflict_cnt;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4)
  ) dut (
    .clk(clk), .rstn(rstn),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy),
    .perf_if_cnt(perf_if_cnt), .perf_d_cnt(perf_d_cnt),
    .perf_conflict_cnt(perf_conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ir;   logic [31:0] ia;
    logic        dr;   logic        dw;   logic [31:0] da;   logic [31:0] dd;
    logic [31:0] mr;
    logic        eig;  logic        eiv;  logic [31:0] eird;
    logic        edg;  logic        edv;  logic [31:0] edrd;
    logic        ecs;  logic        ewe;  logic [31:0] ea;   logic [31:0] ewd;
    logic        eb;
  } vec_t;

  vec_t vecs[$];
  int   n_vec;
  int   n_err;

  function automatic vec_t v(
    logic ir, logic [31:0] ia, logic dr, logic dw, logic [31:0] da, logic [31:0] dd,
    logic [31:0] mr, logic eig, logic eiv, logic [31:0] eird, logic edg, logic edv,
    logic [31:0] edrd, logic ecs, logic ewe, logic [31:0] ea, logic [31:0] ewd, logic eb);
    vec_t r;
    r.ir = ir;   r.ia = ia;   r.dr = dr;   r.dw = dw;   r.da = da;   r.dd = dd;
    r.mr = mr;   r.eig = eig; r.eiv = eiv; r.eird = eird;
    r.edg = edg; r.edv = edv; r.edrd = edrd;
    r.ecs = ecs; r.ewe = ewe; r.ea = ea;   r.ewd = ewd; r.eb = eb;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".if_gnt"},    32'(if_gnt),    32'd0);
    chk({tag, ".if_rvalid"}, 32'(if_rvalid), 32'd0);
    chk({tag, ".if_rdata"},  if_rdata,       32'd0);
    chk({tag, ".d_gnt"},     32'(d_gnt),     32'd0);
    chk({tag, ".d_rvalid"},  32'(d_rvalid),  32'd0);
    chk({tag, ".d_rdata"},   d_rdata,        32'd0);
    chk({tag, ".mem_cs"},    32'(mem_cs),    32'd0);
    chk({tag, ".mem_we"},    32'(mem_we),    32'd0);
    chk({tag, ".mem_addr"},  mem_addr,       32'd0);
    chk({tag, ".mem_wdata"}, mem_wdata,      32'd0);
    chk({tag, ".busy"},      32'(busy),      32'd0);
    chk({tag, ".perf_if"},   perf_if_cnt,    32'd0);
    chk({tag, ".perf_d"},    perf_d_cnt,     32'd0);
    chk({tag, ".perf_cf"},   perf_conflict_cnt, 32'd0);
  endtask

  task automatic drive_idle();
    if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; mem_rdata = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0;
    n_err = 0;

    // Lone fetch from 0x10
    vecs.push_back(v(H,32'h10, L,L,32'h0,32'h0, 32'h0,        L,L,32'h0,        L,L,32'h0, L,L,32'h0,32'h0, L));
    vecs.push_back(v(H,32'h10, L,L,32'h0,32'h0, 32'h0,        H,L,32'h0,        L,L,32'h0, H,L,32'h10,32'h0, H));
    vecs.push_back(v(L,32'h0,  L,L,32'h0,32'h0, 32'h0,        L,L,32'h0,        L,L,32'h0, L,L,32'h0,32'h0, H));
    vecs.push_back(v(L,32'h0,  L,L,32'h0,32'h0, 32'h00500093, L,L,32'h0,        L,L,32'h0, L,L,32'h0,32'h0, H));
    vecs.push_back(v(L,32'h0,  L,L,32'h0,32'h0, 32'h0,        L,H,32'h00500093, L,L,32'h0, L,L,32'h0,32'h0, L));
    // Store 0xDEADBEEF to 0x40, then load back-to-back from the rvalid cycle
    vecs.push_back(v(L,32'h0, H,H,32'h40,32'hDEADBEEF, 32'h0,        L,L,32'h0, L,L,32'h0,        L,L,32'h0,32'h0, L));
    vecs.push_back(v(L,32'h0, H,H,32'h40,32'hDEADBEEF, 32'h0,        L,L,32'h0, H,L,32'h0,        H,H,32'h40,32'hDEADBEEF, H));
    vecs.push_back(v(L,32'h0, L,L,32'h0,32'h0,         32'h0,        L,L,32'h0, L,L,32'h0,        L,L,32'h0,32'h0, H));
    vecs.push_back(v(L,32'h0, L,L,32'h0,32'h0,         32'h12345678, L,L,32'h0, L,L,32'h0,        L,L,32'h0,32'h0, H));
    vecs.push_back(v(L,32'h0, H,L,32'h40,32'h0,        32'h0,        L,L,32'h0, L,H,32'h0,        L,L,32'h0,32'h0, L));
    vecs.push_back(v(L,32'h0, H,L,32'h40,32'h0,        32'h0,        L,L,32'h0, H,L,32'h0,        H,L,32'h40,32'h0, H));
    vecs.push_back(v(L,32'h0, L,L,32'h0,32'h0,         32'h0,        L,L,32'h0, L,L,32'h0,        L,L,32'h0,32'h0, H));
    vecs.push_back(v(L,32'h0, L,L,32'h0,32'h0,         32'hDEADBEEF, L,L,32'h0, L,L,32'h0,        L,L,32'h0,32'h0, H));
    vecs.push_back(v(L,32'h0, L,L,32'h0,32'h0,         32'h0,        L,L,32'h0, L,H,32'hDEADBEEF, L,L,32'h0,32'h0, L));
    // Simultaneous fetch (0x20) and load (0x80): data first, fetch at cycle 5
    vecs.push_back(v(H,32'h20, H,L,32'h80,32'h0, 32'h0,        L,L,32'h0,  L,L,32'h0,        L,L,32'h0,32'h0, L));
    vecs.push_back(v(H,32'h20, H,L,32'h80,32'h0, 32'h0,        L,L,32'h0,  H,L,32'h0,        H,L,32'h80,32'h0, H));
    vecs.push_back(v(H,32'h20, L,L,32'h0,32'h0,  32'h0,        L,L,32'h0,  L,L,32'h0,        L,L,32'h0,32'h0, H));
    vecs.push_back(v(H,32'h20, L,L,32'h0,32'h0,  32'hAAAA5555, L,L,32'h0,  L,L,32'h0,        L,L,32'h0,32'h0, H));
    vecs.push_back(v(H,32'h20, L,L,32'h0,32'h0,  32'h0,        L,L,32'h0,  L,H,32'hAAAA5555, L,L,32'h0,32'h0, L));
    vecs.push_back(v(H,32'h20, L,L,32'h0,32'h0,  32'h0,        H,L,32'h0,  L,L,32'h0,        H,L,32'h20,32'h0, H));
    vecs.push_back(v(L,32'h0,  L,L,32'h0,32'h0,  32'h0,        L,L,32'h0,  L,L,32'h0,        L,L,32'h0,32'h0, H));
    vecs.push_back(v(L,32'h0,  L,L,32'h0,32'h0,  32'h00000013, L,L,32'h0,  L,L,32'h0,        L,L,32'h0,32'h0, H));
    vecs.push_back(v(L,32'h0,  L,L,32'h0,32'h0,  32'h0,        L,H,32'h13, L,L,32'h0,        L,L,32'h0,32'h0, L));

    // Reset state
    rstn = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    rstn = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      if_req = vecs[i].ir; if_addr = vecs[i].ia;
      d_req = vecs[i].dr;  d_we = vecs[i].dw; d_addr = vecs[i].da; d_wdata = vecs[i].dd;
      mem_rdata = vecs[i].mr;
      @(negedge clk);
      chk($sformatf("row%0d.if_gnt", i),    32'(if_gnt),    32'(vecs[i].eig));
      chk($sformatf("row%0d.if_rvalid", i), 32'(if_rvalid), 32'(vecs[i].eiv));
      chk($sformatf("row%0d.d_gnt", i),     32'(d_gnt),     32'(vecs[i].edg));
      chk($sformatf("row%0d.d_rvalid", i),  32'(d_rvalid),  32'(vecs[i].edv));
      chk($sformatf("row%0d.mem_cs", i),    32'(mem_cs),    32'(vecs[i].ecs));
      chk($sformatf("row%0d.busy", i),      32'(busy),      32'(vecs[i].eb));
      if (vecs[i].eiv) chk($sformatf("row%0d.if_rdata", i), if_rdata, vecs[i].eird);
      if (vecs[i].edv) chk($sformatf("row%0d.d_rdata", i),  d_rdata,  vecs[i].edrd);
      if (vecs[i].ecs) begin
        chk($sformatf("row%0d.mem_addr", i), mem_addr,       vecs[i].ea);
        chk($sformatf("row%0d.mem_we", i),   32'(mem_we),    32'(vecs[i].ewe));
        if (vecs[i].ewe) chk($sformatf("row%0d.mem_wdata", i), mem_wdata, vecs[i].ewd);
      end
    end

    // Starvation: both held high, expect D x4, IF, D at a 4-cycle cadence
    @(posedge clk);
    #1;
    drive_idle();
    if_req = 1'b1; if_addr = 32'h100; d_req = 1'b1; d_addr = 32'h200;
    begin
      int grants;
      int cyc;
      int last;
      grants = 0;
      cyc    = 0;
      last   = -1;
      while (grants < 6 && cyc < 60) begin
        @(negedge clk);
        cyc++;
        if (if_gnt || d_gnt) begin
          chk($sformatf("starve_g%0d.if_win", grants), 32'(if_gnt), (grants == 4) ? 32'd1 : 32'd0);
          chk($sformatf("starve_g%0d.one_gnt", grants), 32'(if_gnt & d_gnt), 32'd0);
          if (last >= 0) chk($sformatf("starve_g%0d.period", grants), 32'(cyc - last), 32'd4);
          last = cyc;
          grants++;
        end
      end
      chk("starve_grant_count", 32'(grants), 32'd6);
    end
    @(posedge clk);
    #1;
    drive_idle();
    repeat (8) @(posedge clk);

    // Asynchronous reset in the middle of a store's WAIT period
    #1;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h44; d_wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    d_req = 1'b0; d_we = 1'b0;
    @(posedge clk);
    #1;
    chk("pre_reset.busy", 32'(busy), 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    chk_all_zero("mid_wait_reset");
    @(negedge clk);
    rstn = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("post_reset%0d.d_rvalid", k),  32'(d_rvalid),  32'd0);
      chk($sformatf("post_reset%0d.if_rvalid", k), 32'(if_rvalid), 32'd0);
      chk($sformatf("post_reset%0d.busy", k),      32'(busy),      32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
